// File: rtl/inst_fetch_bridge_if.sv
// Instruction-side SRAM-like bus between the fetch bridge and the instruction memory.
//   inst_req      master -> slave  request valid; address is held until accepted
//   inst_addr     master -> slave  word-aligned fetch address
//   inst_addr_ok  slave -> master  address accepted this cycle
//   inst_data_ok  slave -> master  read data returned this cycle
//   inst_rdata    slave -> master  read data, valid with inst_data_ok
interface inst_fetch_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge. Takes the fetch address from the PC generator, runs one
// request/response transaction on the instruction bus, and hands the fetched word plus
// its PC to the IF/ID register. Requests a pipeline stall while the fetch for pc_i is
// not yet delivered, and discards wrong-path responses after a branch redirect.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   ce_i, pc_i    PC generator enable and fetch address
//   flush_i       branch redirect: current or in-flight fetch is wrong-path
//   stall_i       IF/ID stalled; hold the delivered instruction
//   stallreq_o    to control: fetch for pc_i not yet delivered (combinational)
//   inst_valid_o  inst_o / inst_pc_o valid
//   inst_o        fetched instruction word
//   inst_pc_o     full PC of inst_o (low bits preserved)
//   bus           instruction bus master port
module inst_fetch_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                flush_i,
  input  logic                stall_i,
  output logic                stallreq_o,
  output logic                inst_valid_o,
  output logic [DATA_W-1:0]   inst_o,
  output logic [ADDR_W-1:0]   inst_pc_o,
  inst_fetch_bridge_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      discard_q <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      StIdle: begin
        if (ce_i && !flush_i) begin
          addr_d  = pc_i;
          state_d = StReq;
        end
      end
      StReq: begin
        // A redirect cannot retract the request; mark the response for dropping instead.
        // data_ok seen here belongs to a transaction issued before reset and is ignored.
        if (flush_i) discard_d = 1'b1;
        if (bus.inst_addr_ok) state_d = StWait;
      end
      StWait: begin
        if (bus.inst_data_ok) begin
          if (discard_q || flush_i || !ce_i) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            inst_d    = bus.inst_rdata;
            inst_pc_d = addr_q;
            state_d   = StHold;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        // Flush and loss of ce_i both win over stall_i: the word is withdrawn.
        if (flush_i || !ce_i || !stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.inst_req  = (state_q == StReq);
  assign bus.inst_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign inst_valid_o  = (state_q == StHold);
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign stallreq_o    = ce_i && (state_q != StHold);

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge; the bench plays the instruction memory.
module tb_inst_fetch_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        stall_i;
  logic        stallreq_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .stallreq_o   (stallreq_o),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0; stall_i = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;

    // 1: reset state and minimum latency fetch of pc 0x0
    tick(); tick();
    rst = 1'b0; #1;
    check("rst_req", bus.inst_req, 1'b0);
    check("rst_valid", inst_valid_o, 1'b0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_inst_pc", inst_pc_o, 32'h0);
    check("rst_addr", bus.inst_addr, 32'h0);
    check("t1_stallreq_T", stallreq_o, 1'b1);
    tick(); bus.inst_addr_ok = 1'b1; #1;
    check("t1_req_T1", bus.inst_req, 1'b1);
    check("t1_addr_T1", bus.inst_addr, 32'h0);
    check("t1_stallreq_T1", stallreq_o, 1'b1);
    tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1234_5678; #1;
    check("t1_req_T2", bus.inst_req, 1'b0);
    check("t1_valid_T2", inst_valid_o, 1'b0);
    check("t1_stallreq_T2", stallreq_o, 1'b1);
    tick(); bus.inst_data_ok = 1'b0; #1;
    check("t1_valid_T3", inst_valid_o, 1'b1);
    check("t1_inst_T3", inst_o, 32'h1234_5678);
    check("t1_pc_T3", inst_pc_o, 32'h0);
    check("t1_stallreq_T3", stallreq_o, 1'b0);
    tick(); ce_i = 1'b0; #1;
    check("t1_consumed", inst_valid_o, 1'b0);

    // 2: delayed address acceptance, pc low bits ignored for addressing
    tick(); ce_i = 1'b1; pc_i = 32'h102; #1;
    check("t2_idle_req", bus.inst_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t2_req_held", bus.inst_req, 1'b1);
      check("t2_addr_held", bus.inst_addr, 32'h100);
    end
    tick(); bus.inst_addr_ok = 1'b1; #1;
    check("t2_req_acc", bus.inst_req, 1'b1);
    check("t2_addr_acc", bus.inst_addr, 32'h100);
    tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hCAFE_0001; #1;
    check("t2_wait_req", bus.inst_req, 1'b0);
    check("t2_wait_valid", inst_valid_o, 1'b0);
    tick(); bus.inst_data_ok = 1'b0; ce_i = 1'b0; #1;
    check("t2_valid", inst_valid_o, 1'b1);
    check("t2_inst", inst_o, 32'hCAFE_0001);
    check("t2_pc", inst_pc_o, 32'h102);
    tick(); #1;
    check("t2_ce0_valid", inst_valid_o, 1'b0);
    check("t2_single_txn", bus.inst_req, 1'b0);

    // 3: flush while waiting for pc 0x8, then redirect fetch of 0x40
    tick(); ce_i = 1'b1; pc_i = 32'h8; #1;
    tick(); bus.inst_addr_ok = 1'b1; #1;
    check("t3_addr8", bus.inst_addr, 32'h8);
    tick(); bus.inst_addr_ok = 1'b0; flush_i = 1'b1; pc_i = 32'h40; #1;
    check("t3_wait_req", bus.inst_req, 1'b0);
    tick(); flush_i = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEAD_BEEF; #1;
    check("t3_no_valid_a", inst_valid_o, 1'b0);
    tick(); bus.inst_data_ok = 1'b0; #1;
    check("t3_no_valid_b", inst_valid_o, 1'b0);
    check("t3_idle_req", bus.inst_req, 1'b0);
    tick(); bus.inst_addr_ok = 1'b1; #1;
    check("t3_req40", bus.inst_req, 1'b1);
    check("t3_addr40", bus.inst_addr, 32'h40);
    tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h0BAD_F00D; #1;
    tick(); bus.inst_data_ok = 1'b0; stall_i = 1'b1; #1;
    check("t3_valid", inst_valid_o, 1'b1);
    check("t3_inst", inst_o, 32'h0BAD_F00D);
    check("t3_pc", inst_pc_o, 32'h40);

    // 4: hold under stall for 4 cycles, then consume
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t4_valid", inst_valid_o, 1'b1);
      check("t4_inst", inst_o, 32'h0BAD_F00D);
      check("t4_pc", inst_pc_o, 32'h40);
      check("t4_stallreq", stallreq_o, 1'b0);
    end
    tick(); stall_i = 1'b0; #1;
    check("t4_last_hold", inst_valid_o, 1'b1);
    tick(); ce_i = 1'b0; #1;
    check("t4_idle_valid", inst_valid_o, 1'b0);
    check("t4_idle_req", bus.inst_req, 1'b0);

    // 5: reset during WAIT, late data_ok ignored
    tick(); ce_i = 1'b1; pc_i = 32'h200; #1;
    tick(); bus.inst_addr_ok = 1'b1; #1;
    check("t5_addr", bus.inst_addr, 32'h200);
    tick(); bus.inst_addr_ok = 1'b0; rst = 1'b1; #1;
    tick(); rst = 1'b0; ce_i = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h55; #1;
    check("t5_req", bus.inst_req, 1'b0);
    check("t5_addr_rst", bus.inst_addr, 32'h0);
    check("t5_valid_a", inst_valid_o, 1'b0);
    tick(); bus.inst_data_ok = 1'b0; #1;
    check("t5_valid_b", inst_valid_o, 1'b0);
    check("t5_inst", inst_o, 32'h0);

    // 6: flush has priority over stall in HOLD
    tick(); ce_i = 1'b1; pc_i = 32'h300; #1;
    tick(); bus.inst_addr_ok = 1'b1; #1;
    tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h66; #1;
    tick(); bus.inst_data_ok = 1'b0; flush_i = 1'b1; stall_i = 1'b1; #1;
    check("t6_valid", inst_valid_o, 1'b1);
    check("t6_inst", inst_o, 32'h66);
    check("t6_pc", inst_pc_o, 32'h300);
    tick(); flush_i = 1'b0; stall_i = 1'b0; #1;
    check("t6_flushed", inst_valid_o, 1'b0);
    check("t6_idle_req", bus.inst_req, 1'b0);
    check("t6_stallreq", stallreq_o, 1'b1);
    tick(); ce_i = 1'b0; #1;
    check("t6_refetch_req", bus.inst_req, 1'b1);
    check("t6_refetch_addr", bus.inst_addr, 32'h300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
